xadc_joy_sequencer: RTL and testbench
=====================================

# xadc_joy_sequencer

Sequencer for the XADC DRP port that turns the four joystick auxiliary channels into per-player movement and kick commands. It round-robins DRP reads of aux6, aux14, aux7 and aux15 using a proper den/drdy handshake, with a timeout on each read. Each completed round latches all decoded outputs together, so the game logic never sees a mix of two rounds. It sits between `xadc_wiz_0` and the player-movement and hit logic in the top level.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1000: idle clocks between consecutive DRP reads. Minimum 1.
- `TIMEOUT_CYCLES`, 255: maximum clocks spent waiting for `drp_drdy` before the channel is skipped.
- `DEADBAND`, 1: half-width of the centre dead zone in nibble units. Legal range 0..7.

Ports:
- `clk`  in  1: system clock. Only one clock is used.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `drp_daddr`  out  7: DRP address.
- `drp_den`  out  1: DRP enable, a single-cycle pulse.
- `drp_dwe`  out  1: DRP write enable, tied to 0.
- `drp_do`  in  16: DRP read data. Only bits [15:12] are used.
- `drp_drdy`  in  1: DRP data ready.
- `p1_dx`, `p1_dy`, `p2_dx`, `p2_dy`  out  2 each: signed step, one of -1, 0 or +1.
- `p1_kick`, `p2_kick`  out  1 each: kick held.
- `raw`  out  16: latched nibbles, `{ch3,ch2,ch1,ch0}`.
- `round_done`  out  1: one-cycle pulse when a new output set is published.
- `timeout_err`  out  1: one-cycle pulse when a channel read times out.

## Operation
- Channel order and addresses:
  - ch0 = 0x16, P1 X
  - ch1 = 0x1E, P1 Y
  - ch2 = 0x17, P2 X
  - ch3 = 0x1F, P2 Y
- FSM states:
  - SETTLE: count `SETTLE_CYCLES`, then go to REQ.
  - REQ: drive `drp_daddr` with the current channel address, assert `drp_den` for one cycle, go to WAIT.
  - WAIT: on `drp_drdy`, capture `drp_do[15:12]` into that channel's shadow nibble and go to NEXT. If the timeout counter reaches `TIMEOUT_CYCLES`, pulse `timeout_err`, keep the old nibble, and go to NEXT.
  - NEXT: if channel index = 3, go to PUBLISH. Otherwise increment the index and go to SETTLE.
  - PUBLISH: copy all shadow nibbles to `raw`, update every decoded output, pulse `round_done`, reset the index to 0, go to SETTLE.
- Decode rules. Nibble `n` is compared in 5-bit unsigned arithmetic: `hi` = n > 8+DEADBAND, `lo` = n + DEADBAND < 8.
  - X axis: `hi` gives +1, `lo` gives -1, otherwise 0.
  - Y axis: `hi` gives dy = +1 and kick = 0. `lo` gives dy = 0 and kick = 1. Otherwise dy = 0 and kick = 0.
- `drp_drdy` is ignored in every state except WAIT.
- `drp_dwe` is always 0.

## Timing
- Reset values:
  - FSM in SETTLE, index 0, counters 0.
  - `drp_den`, `round_done`, `timeout_err` = 0.
  - `drp_daddr` = 0x16.
  - Shadow nibbles and `raw` = 0x8888.
  - All dx/dy = 0, all kicks = 0.
- `drp_daddr` is stable from REQ until the cycle after WAIT exits.
- Capture happens on the `drp_drdy` cycle. Decoded outputs change in the PUBLISH cycle, and the outputs are registered, so they are visible the following cycle, coincident with `round_done`.
- Minimum round length: 4 × (`SETTLE_CYCLES` + 1 REQ + 1 WAIT + 1 NEXT) + 1 PUBLISH.
- Timeout: `timeout_err` pulses exactly `TIMEOUT_CYCLES` clocks after `drp_den`.
- If `drp_drdy` arrives on the same cycle the timeout would fire, the capture wins and no error is raised.
- If `rst_n` is asserted mid-read, everything returns to reset values immediately. A late `drp_drdy` arriving after release lands in SETTLE and is ignored.
- No output changes between PUBLISH pulses.

## Structure
- Package `xadc_joy_pkg` holds:
  - the FSM state enum
  - the four channel address constants
  - the channel count (4)
  - the axis step encodings (-1, 0, +1)
- Sub-module `axis_decode`: combinational. Takes a nibble and `DEADBAND`, returns `hi` and `lo`. Instantiated four times.

## Test plan
- Reset, then a DRP model returning 0xF000 on every channel with 2-cycle latency: after the first `round_done`, `p1_dx` = +1, `p1_dy` = +1, `p1_kick` = 0, and the same for P2; `raw` = 0xFFFF.
- Nibbles ch0..ch3 = 0x0, 0x0, 0x8, 0x9 with `DEADBAND` = 1: `p1_dx` = -1, `p1_kick` = 1, `p1_dy` = 0, `p2_dx` = 0, `p2_dy` = 0, `p2_kick` = 0.
- Model never answers ch2: `timeout_err` pulses 255 cycles after that channel's `drp_den`, the ch2 nibble keeps its previous value, and `round_done` still fires.
- Check `drp_den` pulse width = 1, `drp_daddr` sequence 0x16, 0x1E, 0x17, 0x1F repeating, `drp_dwe` = 0 throughout, and no output change between `round_done` pulses.
- Assert `rst_n` during a WAIT, then deliver `drp_drdy` after release: outputs are at reset values, no capture occurs, and the next read is ch0 at 0x16.

Source files
------------

// File: rtl/xadc_joy_pkg.sv
// Shared types and constants for the XADC joystick sequencer: FSM states, DRP channel
// addresses and the signed 2-bit step encodings.
package xadc_joy_pkg;

  typedef enum logic [2:0] {
    StSettle,
    StReq,
    StWait,
    StNext,
    StPublish
  } state_e;

  localparam int unsigned NumCh = 4;

  localparam logic [6:0] AddrCh0 = 7'h16;  // aux6,  P1 X
  localparam logic [6:0] AddrCh1 = 7'h1E;  // aux14, P1 Y
  localparam logic [6:0] AddrCh2 = 7'h17;  // aux7,  P2 X
  localparam logic [6:0] AddrCh3 = 7'h1F;  // aux15, P2 Y

  localparam logic [1:0] StepNeg  = 2'b11;
  localparam logic [1:0] StepZero = 2'b00;
  localparam logic [1:0] StepPos  = 2'b01;

  function automatic logic [6:0] ch_addr(input logic [1:0] idx);
    logic [6:0] addr;
    unique case (idx)
      2'd0:    addr = AddrCh0;
      2'd1:    addr = AddrCh1;
      2'd2:    addr = AddrCh2;
      default: addr = AddrCh3;
    endcase
    return addr;
  endfunction

  function automatic logic [1:0] x_step(input logic hi, input logic lo);
    if (hi)      return StepPos;
    else if (lo) return StepNeg;
    else         return StepZero;
  endfunction

endpackage

// File: rtl/axis_decode.sv
// Dead-zone comparator for one joystick nibble; hi/lo are mutually exclusive for
// any DEADBAND in 0..7.
module axis_decode #(
  parameter int unsigned DEADBAND = 1
) (
  input  logic [3:0] nibble_i,
  output logic       hi_o,
  output logic       lo_o
);

  localparam logic [4:0] Db = 5'(DEADBAND);

  logic [4:0] n5;
  assign n5   = {1'b0, nibble_i};
  assign hi_o = n5 > (5'd8 + Db);
  assign lo_o = (n5 + Db) < 5'd8;

endmodule

// File: rtl/xadc_joy_sequencer.sv
// Round-robin DRP reader for the four joystick aux channels; decoded movement and
// kick outputs are published atomically once per completed round.
module xadc_joy_sequencer
  import xadc_joy_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DEADBAND       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [1:0]  p1_dx,
  output logic [1:0]  p1_dy,
  output logic [1:0]  p2_dx,
  output logic [1:0]  p2_dy,
  output logic        p1_kick,
  output logic        p2_kick,
  output logic [15:0] raw,
  output logic        round_done,
  output logic        timeout_err
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [15:0] Centre = 16'h8888;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     raw_q, raw_d;
  logic [6:0]      daddr_q, daddr_d;
  logic            den_q, den_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      p1_dx_q, p1_dx_d, p1_dy_q, p1_dy_d;
  logic [1:0]      p2_dx_q, p2_dx_d, p2_dy_q, p2_dy_d;
  logic            p1_kick_q, p1_kick_d, p2_kick_q, p2_kick_d;

  logic [NumCh-1:0] hi, lo;

  // Only the top nibble of the 12-bit conversion is used.
  logic unused_do_bits;
  assign unused_do_bits = ^drp_do[11:0];

  for (genvar g = 0; g < NumCh; g++) begin : g_dec
    axis_decode #(
      .DEADBAND(DEADBAND)
    ) u_dec (
      .nibble_i(shadow_q[4*g +: 4]),
      .hi_o    (hi[g]),
      .lo_o    (lo[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    raw_d     = raw_q;
    daddr_d   = daddr_q;
    den_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    p1_dx_d   = p1_dx_q;
    p1_dy_d   = p1_dy_q;
    p2_dx_d   = p2_dx_q;
    p2_dy_d   = p2_dy_q;
    p1_kick_d = p1_kick_q;
    p2_kick_d = p2_kick_q;

    unique case (state_q)
      StSettle: begin
        if (cnt_q >= CntW'(SETTLE_CYCLES - 1)) begin
          state_d = StReq;
          cnt_d   = '0;
          daddr_d = ch_addr(idx_q);
          den_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReq: begin
        // cnt tracks clocks since the den pulse while waiting.
        state_d = StWait;
        cnt_d   = CntW'(1);
      end
      StWait: begin
        if (drp_drdy) begin
          shadow_d[{idx_q, 2'b00} +: 4] = drp_do[15:12];
          state_d = StNext;
          cnt_d   = '0;
        end else if (cnt_q >= CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StNext;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StNext: begin
        if (idx_q == 2'd3) begin
          state_d = StPublish;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StSettle;
        end
      end
      StPublish: begin
        raw_d     = shadow_q;
        p1_dx_d   = x_step(hi[0], lo[0]);
        p1_dy_d   = hi[1] ? StepPos : StepZero;
        p1_kick_d = lo[1];
        p2_dx_d   = x_step(hi[2], lo[2]);
        p2_dy_d   = hi[3] ? StepPos : StepZero;
        p2_kick_d = lo[3];
        done_d    = 1'b1;
        idx_d     = 2'd0;
        state_d   = StSettle;
      end
      default: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StSettle;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      shadow_q  <= Centre;
      raw_q     <= Centre;
      daddr_q   <= AddrCh0;
      den_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      p1_dx_q   <= StepZero;
      p1_dy_q   <= StepZero;
      p2_dx_q   <= StepZero;
      p2_dy_q   <= StepZero;
      p1_kick_q <= 1'b0;
      p2_kick_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      raw_q     <= raw_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      done_q    <= done_d;
      err_q     <= err_d;
      p1_dx_q   <= p1_dx_d;
      p1_dy_q   <= p1_dy_d;
      p2_dx_q   <= p2_dx_d;
      p2_dy_q   <= p2_dy_d;
      p1_kick_q <= p1_kick_d;
      p2_kick_q <= p2_kick_d;
    end
  end

  assign drp_daddr   = daddr_q;
  assign drp_den     = den_q;
  assign drp_dwe     = 1'b0;
  assign raw         = raw_q;
  assign round_done  = done_q;
  assign timeout_err = err_q;
  assign p1_dx       = p1_dx_q;
  assign p1_dy       = p1_dy_q;
  assign p2_dx       = p2_dx_q;
  assign p2_dy       = p2_dy_q;
  assign p1_kick     = p1_kick_q;
  assign p2_kick     = p2_kick_q;

endmodule

// File: tb/tb_xadc_joy_sequencer.sv
// Directed bench: a latency-2 DRP model with per-channel mute drives the sequencer
// through decode vectors, a timeout round and a reset during WAIT.
module tb_xadc_joy_sequencer;

  localparam int unsigned Settle  = 4;
  localparam int unsigned Timeout = 255;
  localparam int unsigned Lat     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [15:0] drp_do;
  logic [1:0]  p1_dx, p1_dy, p2_dx, p2_dy;
  logic        p1_kick, p2_kick, round_done, timeout_err;
  logic [15:0] raw;

  xadc_joy_sequencer #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout),
    .DEADBAND      (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .p1_dx      (p1_dx),
    .p1_dy      (p1_dy),
    .p2_dx      (p2_dx),
    .p2_dy      (p2_dy),
    .p1_kick    (p1_kick),
    .p2_kick    (p2_kick),
    .raw        (raw),
    .round_done (round_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRP model
  logic [3:0]  nib [4];
  logic [3:0]  mute = 4'b0000;
  logic        model_drdy = 1'b0;
  logic [15:0] model_do = 16'h0123;
  logic        force_drdy = 1'b0;
  int          pend = 0;
  int          pch = 0;

  assign drp_drdy = model_drdy | force_drdy;
  assign drp_do   = force_drdy ? 16'hF000 : model_do;

  function automatic int addr_to_ch(input logic [6:0] a);
    case (a)
      7'h16:   return 0;
      7'h1E:   return 1;
      7'h17:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    model_drdy = 1'b0;
    model_do   = 16'h0123;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          model_drdy = 1'b1;
          model_do   = {nib[pch], 12'hABC};
        end
      end
      if (drp_den && !mute[addr_to_ch(drp_daddr)]) begin
        pend = Lat;
        pch  = addr_to_ch(drp_daddr);
      end
    end
  end

  // Monitors
  int          cyc = 0;
  int          last_den_cyc = 0;
  int          tmo_delta = -1;
  int          n_tmo = 0;
  int          den_wide = 0;
  int          dwe_bad = 0;
  int          unstable = 0;
  int          n_addr = 0;
  logic [6:0]  addr_log [12];
  logic        den_prev = 1'b0;
  logic        mon_armed = 1'b0;
  logic [25:0] out_prev = '0;
  logic [25:0] out_cur;

  assign out_cur = {raw, p1_dx, p1_dy, p2_dx, p2_dy, p1_kick, p2_kick};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (drp_dwe !== 1'b0) dwe_bad++;
    if (rst_n) begin
      if (drp_den && den_prev) den_wide++;
      if (drp_den) begin
        last_den_cyc = cyc;
        if (n_addr < 12) begin
          addr_log[n_addr] = drp_daddr;
          n_addr++;
        end
      end
      if (timeout_err) begin
        n_tmo++;
        tmo_delta = cyc - last_den_cyc;
      end
      if (mon_armed && out_cur !== out_prev && !round_done) unstable++;
    end
    den_prev  = drp_den;
    out_prev  = out_cur;
    mon_armed = 1'b1;
  end

  task automatic wait_round(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (round_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("round_done_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_den(input logic [6:0] addr, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drp_den && drp_daddr == addr) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("den_wait", 32'd0, 32'd1);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e_raw,
                            input logic [1:0] e_p1dx, input logic [1:0] e_p1dy,
                            input logic e_p1k, input logic [1:0] e_p2dx,
                            input logic [1:0] e_p2dy, input logic e_p2k);
    check_val({tag, ".raw"}, 32'(raw), 32'(e_raw));
    check_val({tag, ".p1_dx"}, 32'(p1_dx), 32'(e_p1dx));
    check_val({tag, ".p1_dy"}, 32'(p1_dy), 32'(e_p1dy));
    check_val({tag, ".p1_kick"}, 32'(p1_kick), 32'(e_p1k));
    check_val({tag, ".p2_dx"}, 32'(p2_dx), 32'(e_p2dx));
    check_val({tag, ".p2_dy"}, 32'(p2_dy), 32'(e_p2dy));
    check_val({tag, ".p2_kick"}, 32'(p2_kick), 32'(e_p2k));
  endtask

  initial begin
    logic [6:0] exp_addr [4];
    exp_addr[0] = 7'h16;
    exp_addr[1] = 7'h1E;
    exp_addr[2] = 7'h17;
    exp_addr[3] = 7'h1F;
    for (int i = 0; i < 4; i++) nib[i] = 4'hF;

    repeat (3) @(negedge clk);
    check_outs("reset", 16'h8888, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    check_val("reset.daddr", 32'(drp_daddr), 32'h16);
    check_val("reset.den", 32'(drp_den), 32'd0);
    check_val("reset.round_done", 32'(round_done), 32'd0);
    check_val("reset.timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // All channels full scale
    wait_round(200);
    check_outs("full", 16'hFFFF, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0);

    // ch0..ch3 = 0,0,8,9: 8 and 9 sit inside the dead zone
    nib[0] = 4'h0; nib[1] = 4'h0; nib[2] = 4'h8; nib[3] = 4'h9;
    wait_round(200);
    check_outs("low", 16'h9800, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0);

    // Dead-zone edges: 7 centred, 6 low, 10 high
    nib[0] = 4'h7; nib[1] = 4'h6; nib[2] = 4'hA; nib[3] = 4'hA;
    wait_round(200);
    check_outs("edge", 16'hAA67, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0);

    // ch2 never answers: its nibble keeps 0xA
    nib[0] = 4'h1; nib[1] = 4'h2; nib[2] = 4'h3; nib[3] = 4'h4;
    mute = 4'b0100;
    wait_round(800);
    check_outs("tmo", 16'h4A21, 2'b11, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1);
    check_val("tmo.delta", 32'(tmo_delta), 32'(Timeout));
    check_val("tmo.count", 32'(n_tmo), 32'd1);

    for (int i = 0; i < 12; i++) check_val($sformatf("addr_seq[%0d]", i),
                                           32'(addr_log[i]), 32'(exp_addr[i % 4]));

    // Reset during the ch1 WAIT, then a stray drdy after release
    mute = 4'b1110;
    wait_den(7'h1E, 400);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nib[0] = 4'h5; nib[1] = 4'h5; nib[2] = 4'h5; nib[3] = 4'h5;
    mute = 4'b0001;
    @(negedge clk);
    force_drdy = 1'b1;
    @(negedge clk);
    force_drdy = 1'b0;
    check_outs("midrst", 16'h8888, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    check_val("midrst.daddr", 32'(drp_daddr), 32'h16);
    wait_den(7'h16, 100);
    check_val("midrst.first_addr", 32'(drp_daddr), 32'h16);
    // ch0 times out, so it shows the reset centre value unless the stray drdy landed
    wait_round(800);
    check_outs("post", 16'h5558, 2'b00, 2'b00, 1'b1, 2'b11, 2'b00, 1'b1);
    check_val("post.tmo_count", 32'(n_tmo), 32'd2);

    check_val("den_width", 32'(den_wide), 32'd0);
    check_val("dwe_zero", 32'(dwe_bad), 32'd0);
    check_val("out_stable", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
